// File: rtl/axi4_lite_reg_file_pkg.sv
// axi4_lite_reg_file_pkg: response codes, FSM state encodings and address LSB helper
package axi4_lite_reg_file_pkg;
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;
  typedef enum logic [2:0] {
    WR_IDLE,
    WR_HAVE_ADDR,
    WR_HAVE_DATA,
    WR_COMMIT,
    WR_RESP
  } wr_state_e;
  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_e;
  function automatic int lsb_f(input int data_w);
    return $clog2(data_w / 8);
  endfunction
endpackage

// File: rtl/aix4_lite_if.sv
// aix4_lite_if: AXI4-Lite bundle with slave and master modports
interface aix4_lite_if #(
  parameter int ADDR_BIT_WIDTH = 8,
  parameter int DATA_BIT_WIDTH = 32
);
  logic [ADDR_BIT_WIDTH-1:0]   awaddr, araddr;
  logic [DATA_BIT_WIDTH-1:0]   wdata, rdata;
  logic [DATA_BIT_WIDTH/8-1:0] wstrb;
  logic [1:0]                  bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  modport slv_port (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport mst_port (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_reg_addr_dec.sv
// axi4_lite_reg_addr_dec: maps a byte address onto RW / RO / unmapped register index
module axi4_lite_reg_addr_dec
  import axi4_lite_reg_file_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int NUM_RW = 8,
  parameter int NUM_RO = 4
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              is_rw,
  output logic              is_ro,
  output logic [ADDR_W-1:0] index
);
  localparam int LSB = lsb_f(DATA_W);
  always_comb begin
    index = addr >> LSB;
    is_rw = 32'(index) < NUM_RW;
    is_ro = !is_rw && 32'(index) < NUM_RW + NUM_RO;
  end
endmodule

// File: rtl/axi4_lite_reg_file.sv
// axi4_lite_reg_file: AXI4-Lite RW/RO register bank with independent AW/W acceptance.
// Define AXI4_LITE_REG_FILE_ERR_RESP_EN for SLVERR/DECERR responses; otherwise all OKAY.
module axi4_lite_reg_file
  import axi4_lite_reg_file_pkg::*;
#(
  parameter int AXI4_LITE_ADDR_BIT_WIDTH = 8,
  parameter int AXI4_LITE_DATA_BIT_WIDTH = 32,
  parameter int NUM_RW_REGS              = 8,
  parameter int NUM_RO_REGS              = 4
) (
  input  logic                                                  i_clk,
  input  logic                                                  i_sync_rst_n,
  aix4_lite_if.slv_port                                         if_s_axi4_lite,
  output logic [NUM_RW_REGS-1:0][AXI4_LITE_DATA_BIT_WIDTH-1:0] o_rw_regs,
  output logic [NUM_RW_REGS-1:0]                                o_wr_pulse,
  input  logic [(NUM_RO_REGS > 0 ? NUM_RO_REGS : 1)-1:0][AXI4_LITE_DATA_BIT_WIDTH-1:0] i_ro_regs
);
  localparam int AW  = AXI4_LITE_ADDR_BIT_WIDTH;
  localparam int DW  = AXI4_LITE_DATA_BIT_WIDTH;
  localparam int SW  = DW / 8;
  localparam int LSB = lsb_f(DW);
`ifdef AXI4_LITE_REG_FILE_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  if (if_s_axi4_lite.ADDR_BIT_WIDTH != AW) begin : g_aw_chk
    $error("address width differs from interface");
  end
  if (if_s_axi4_lite.DATA_BIT_WIDTH != DW) begin : g_dw_chk
    $error("data width differs from interface");
  end
  if (DW != 32 && DW != 64) begin : g_dw_val
    $error("data width must be 32 or 64");
  end
  if (((NUM_RW_REGS + NUM_RO_REGS) << LSB) > (2 ** AW)) begin : g_map_chk
    $error("register map exceeds address space");
  end
  wr_state_e                    wr_state_q, wr_state_d;
  rd_state_e                    rd_state_q, rd_state_d;
  logic [AW-1:0]                awaddr_q, awaddr_d;
  logic [DW-1:0]                wdata_q, wdata_d;
  logic [SW-1:0]                wstrb_q, wstrb_d;
  logic                         awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic                         arready_q, arready_d, rvalid_q, rvalid_d;
  resp_e                        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DW-1:0]                rdata_q, rdata_d;
  logic [NUM_RW_REGS-1:0][DW-1:0] regs_q, regs_d;
  logic [NUM_RW_REGS-1:0]       wr_pulse_q, wr_pulse_d;
  logic                         aw_hs, w_hs, ar_hs, commit;
  logic                         wr_is_rw, wr_is_ro, rd_is_rw, rd_is_ro;
  logic [AW-1:0]                wr_idx, rd_idx;
  axi4_lite_reg_addr_dec #(.ADDR_W(AW), .DATA_W(DW), .NUM_RW(NUM_RW_REGS), .NUM_RO(NUM_RO_REGS)) u_wr_dec (
    .addr(awaddr_q), .is_rw(wr_is_rw), .is_ro(wr_is_ro), .index(wr_idx)
  );
  axi4_lite_reg_addr_dec #(.ADDR_W(AW), .DATA_W(DW), .NUM_RW(NUM_RW_REGS), .NUM_RO(NUM_RO_REGS)) u_rd_dec (
    .addr(if_s_axi4_lite.araddr), .is_rw(rd_is_rw), .is_ro(rd_is_ro), .index(rd_idx)
  );
  always_comb begin
    aw_hs = if_s_axi4_lite.awvalid && awready_q;
    w_hs = if_s_axi4_lite.wvalid && wready_q;
    ar_hs = if_s_axi4_lite.arvalid && arready_q;
    commit = wr_state_q == WR_COMMIT;
    awaddr_d = aw_hs ? if_s_axi4_lite.awaddr : awaddr_q;
    wdata_d = w_hs ? if_s_axi4_lite.wdata : wdata_q;
    wstrb_d = w_hs ? if_s_axi4_lite.wstrb : wstrb_q;
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_IDLE:      wr_state_d = (aw_hs && w_hs) ? WR_COMMIT : aw_hs ? WR_HAVE_ADDR : w_hs ? WR_HAVE_DATA : WR_IDLE;
      WR_HAVE_ADDR: wr_state_d = w_hs ? WR_COMMIT : WR_HAVE_ADDR;
      WR_HAVE_DATA: wr_state_d = aw_hs ? WR_COMMIT : WR_HAVE_DATA;
      WR_COMMIT:    wr_state_d = WR_RESP;
      WR_RESP:      wr_state_d = if_s_axi4_lite.bready ? WR_IDLE : WR_RESP;
      default:      wr_state_d = WR_IDLE;
    endcase
    awready_d = wr_state_d inside {WR_IDLE, WR_HAVE_DATA};
    wready_d = wr_state_d inside {WR_IDLE, WR_HAVE_ADDR};
    bvalid_d = wr_state_d == WR_RESP;
    bresp_d = commit ? ((!ERR_EN || wr_is_rw) ? OKAY : (wr_is_ro ? SLVERR : DECERR)) : bresp_q;
    regs_d = regs_q;
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_RW_REGS; i++) begin
      if (commit && wr_is_rw && 32'(wr_idx) == i) begin
        wr_pulse_d[i] = 1'b1;
        for (int b = 0; b < SW; b++) begin
          if (wstrb_q[b]) regs_d[i][8*b+:8] = wdata_q[8*b+:8];
        end
      end
    end
    rd_state_d = (rd_state_q == RD_IDLE) ? (ar_hs ? RD_RESP : RD_IDLE) : (if_s_axi4_lite.rready ? RD_IDLE : RD_RESP);
    arready_d = rd_state_d == RD_IDLE;
    rvalid_d = rd_state_d == RD_RESP;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    // read samples regs_q, so a same-edge write commit is not yet visible
    if (ar_hs) begin
      rdata_d = '0;
      rresp_d = (!ERR_EN || rd_is_rw || rd_is_ro) ? OKAY : DECERR;
      for (int i = 0; i < NUM_RW_REGS; i++) begin
        if (rd_is_rw && 32'(rd_idx) == i) rdata_d = regs_q[i];
      end
      for (int i = 0; i < NUM_RO_REGS; i++) begin
        if (rd_is_ro && 32'(rd_idx) == NUM_RW_REGS + i) rdata_d = i_ro_regs[i];
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_sync_rst_n) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= OKAY;
      rdata_q    <= '0;
      regs_q     <= '0;
      wr_pulse_q <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end
  assign if_s_axi4_lite.awready = awready_q;
  assign if_s_axi4_lite.wready  = wready_q;
  assign if_s_axi4_lite.bvalid  = bvalid_q;
  assign if_s_axi4_lite.bresp   = bresp_q;
  assign if_s_axi4_lite.arready = arready_q;
  assign if_s_axi4_lite.rvalid  = rvalid_q;
  assign if_s_axi4_lite.rresp   = rresp_q;
  assign if_s_axi4_lite.rdata   = rdata_q;
  assign o_rw_regs  = regs_q;
  assign o_wr_pulse = wr_pulse_q;
endmodule

// File: tb/tb_axi4_lite_reg_file.sv
// tb_axi4_lite_reg_file: directed and randomized checks of axi4_lite_reg_file against a register map model
module tb_axi4_lite_reg_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  aix4_lite_if #(.ADDR_BIT_WIDTH(8), .DATA_BIT_WIDTH(32)) axi ();
  logic [7:0][31:0] rw_regs;
  logic [7:0]       wr_pulse;
  logic [3:0][31:0] ro_regs;
  axi4_lite_reg_file dut (
    .i_clk(clk), .i_sync_rst_n(rst_n), .if_s_axi4_lite(axi),
    .o_rw_regs(rw_regs), .o_wr_pulse(wr_pulse), .i_ro_regs(ro_regs)
  );
`ifdef AXI4_LITE_REG_FILE_ERR_RESP_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic [31:0] m_regs [8];
  int n_vec = 0;
  int n_err = 0;
  function automatic logic [31:0] m_read(input logic [7:0] a);
    int idx = int'(a >> 2);
    return idx < 8 ? m_regs[idx] : idx < 12 ? ro_regs[idx-8] : 32'h0;
  endfunction
  function automatic logic [1:0] m_rresp(input logic [7:0] a);
    return (ERR && (a >> 2) >= 12) ? 2'b11 : 2'b00;
  endfunction
  function automatic logic [1:0] m_bresp(input logic [7:0] a);
    int idx = int'(a >> 2);
    return !ERR ? 2'b00 : idx < 8 ? 2'b00 : idx < 12 ? 2'b10 : 2'b11;
  endfunction
  function automatic logic [7:0] m_pulse(input logic [7:0] a);
    int idx = int'(a >> 2);
    return idx < 8 ? 8'(1 << idx) : 8'h0;
  endfunction
  function automatic logic [7:0][31:0] m_packed();
    logic [7:0][31:0] p;
    for (int i = 0; i < 8; i++) p[i] = m_regs[i];
    return p;
  endfunction
  task automatic m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a >> 2);
    if (idx < 8)
      for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][8*b+:8] = d[8*b+:8];
  endtask
  task automatic idle_inputs();
    axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0; axi.bready = 0; axi.rready = 0;
    axi.awaddr = 0; axi.araddr = 0; axi.wdata = 0; axi.wstrb = 0;
  endtask
  // gap > 0: W leads AW by gap cycles; gap < 0: AW leads W; lat = cycles from last handshake to BVALID
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input int gap,
                           output logic [1:0] resp, output logic [7:0] pulse_or, output int pulse_cyc, output int lat);
    int aw_at, w_at, c, k;
    bit aw_done, w_done, aw_fire, w_fire;
    aw_at = gap > 0 ? gap : 0; w_at = gap < 0 ? -gap : 0;
    aw_done = 0; w_done = 0; c = 0; resp = 2'bxx; pulse_or = 0; pulse_cyc = 0; lat = -1;
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s; axi.bready = 1;
    while (!(aw_done && w_done) && c < 40) begin
      axi.awvalid = !aw_done && c >= aw_at;
      axi.wvalid = !w_done && c >= w_at;
      aw_fire = axi.awvalid && axi.awready;
      w_fire = axi.wvalid && axi.wready;
      @(posedge clk); #1; c++;
      aw_done |= aw_fire; w_done |= w_fire;
    end
    axi.awvalid = 0; axi.wvalid = 0;
    if (aw_done && w_done) begin
      k = 0;
      while (k < 10) begin
        pulse_or |= wr_pulse; if (wr_pulse != 0) pulse_cyc++;
        if (axi.bvalid) begin resp = axi.bresp; lat = k; break; end
        @(posedge clk); #1; k++;
      end
      @(posedge clk); #1;
      pulse_or |= wr_pulse; if (wr_pulse != 0) pulse_cyc++;
    end
    axi.bready = 0;
  endtask
  task automatic axi_read(input logic [7:0] a, input int hold, output logic [31:0] data, output logic [1:0] resp,
                          output int lat, output bit hold_ok);
    int c;
    bit fired;
    axi.araddr = a; axi.arvalid = 1; axi.rready = 0; c = 0; fired = 0; hold_ok = 1;
    while (!fired && c < 40) begin
      fired = axi.arready;
      @(posedge clk); #1; c++;
    end
    axi.arvalid = 0;
    lat = (fired && axi.rvalid) ? 0 : -1;
    data = axi.rdata; resp = axi.rresp;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!axi.rvalid || axi.rdata !== data || axi.rresp !== resp || axi.arready) hold_ok = 0;
    end
    axi.rready = 1;
    @(posedge clk); #1;
    if (axi.rvalid || !axi.arready) hold_ok = 0;
    axi.rready = 0;
  endtask
  task automatic test_reset();
    idle_inputs(); ro_regs = '0; rst_n = 0;
    repeat (3) @(posedge clk); #1;
    n_vec++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, axi.bresp, axi.rresp, axi.rdata} !== '0) begin
      n_err++; $display("FAIL reset_axi_outs got %h expected 0",
        {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, axi.bresp, axi.rresp, axi.rdata});
    end
    n_vec++;
    if ({rw_regs, wr_pulse} !== '0) begin n_err++; $display("FAIL reset_regs got %h expected 0", {rw_regs, wr_pulse}); end
    rst_n = 1;
    @(posedge clk); #1;
    n_vec++;
    if ({axi.awready, axi.wready, axi.arready} !== 3'b111) begin
      n_err++; $display("FAIL reset_ready_rise got %b expected 111", {axi.awready, axi.wready, axi.arready});
    end
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
  endtask
  task automatic test_same_cycle_write();
    logic [1:0] r; logic [7:0] p; int pc, lat;
    axi_write(8'h04, 32'hDEADBEEF, 4'hF, 0, r, p, pc, lat);
    m_write(8'h04, 32'hDEADBEEF, 4'hF);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL same_cycle_lat got %0d expected 1", lat); end
    n_vec++; if (r !== 2'b00) begin n_err++; $display("FAIL same_cycle_bresp got %b expected 00", r); end
    n_vec++; if (p !== 8'b10 || pc !== 1) begin n_err++; $display("FAIL same_cycle_pulse got %b x%0d expected 00000010 x1", p, pc); end
    n_vec++; if (rw_regs[1] !== 32'hDEADBEEF) begin n_err++; $display("FAIL same_cycle_reg1 got %h expected deadbeef", rw_regs[1]); end
  endtask
  task automatic test_split_order();
    logic [1:0] r; logic [7:0] p; int pc, lat;
    for (int pass = 0; pass < 2; pass++) begin
      axi_write(8'h08, 32'h11223344, 4'hF, 0, r, p, pc, lat);
      m_write(8'h08, 32'h11223344, 4'hF);
      axi_write(8'h08, 32'h000000AA, 4'h1, pass == 0 ? 3 : -3, r, p, pc, lat);
      m_write(8'h08, 32'h000000AA, 4'h1);
      n_vec++; if (rw_regs[2] !== 32'h112233AA) begin n_err++; $display("FAIL split_reg2 pass%0d got %h expected 112233aa", pass, rw_regs[2]); end
      n_vec++; if (lat !== 1 || r !== 2'b00 || p !== 8'b100 || pc !== 1) begin
        n_err++; $display("FAIL split_resp pass%0d got lat%0d resp%b pulse%b x%0d expected lat1 resp00 pulse00000100 x1", pass, lat, r, p, pc);
      end
    end
    axi_write(8'h08, 32'hFFFFFFFF, 4'h0, 0, r, p, pc, lat);
    n_vec++; if (rw_regs[2] !== 32'h112233AA || p !== 8'b100 || r !== 2'b00) begin
      n_err++; $display("FAIL zero_strb got reg%h pulse%b resp%b expected reg112233aa pulse00000100 resp00", rw_regs[2], p, r);
    end
  endtask
  task automatic test_ro_read_hold();
    logic [31:0] d; logic [1:0] r; int lat; bit ok;
    ro_regs[0] = 32'h5A5A0001;
    axi_read(8'h20, 5, d, r, lat, ok);
    n_vec++; if (d !== 32'h5A5A0001 || r !== 2'b00) begin n_err++; $display("FAIL ro_read got %h/%b expected 5a5a0001/00", d, r); end
    n_vec++; if (lat !== 0) begin n_err++; $display("FAIL ro_read_lat got %0d expected 0", lat); end
    n_vec++; if (!ok) begin n_err++; $display("FAIL ro_read_hold got unstable expected held"); end
  endtask
  task automatic test_errors();
    logic [1:0] r; logic [7:0] p; int pc, lat; logic [31:0] d; bit ok;
    axi_write(8'h24, 32'hCAFEF00D, 4'hF, 1, r, p, pc, lat);
    n_vec++; if (r !== m_bresp(8'h24) || p !== 8'h0) begin n_err++; $display("FAIL ro_write got resp%b pulse%b expected resp%b pulse0", r, p, m_bresp(8'h24)); end
    n_vec++; if (rw_regs !== m_packed()) begin n_err++; $display("FAIL ro_write_regs got %h expected %h", rw_regs, m_packed()); end
    axi_write(8'h40, 32'h12345678, 4'hF, -2, r, p, pc, lat);
    n_vec++; if (r !== m_bresp(8'h40) || p !== 8'h0 || rw_regs !== m_packed()) begin
      n_err++; $display("FAIL unmapped_write got resp%b pulse%b expected resp%b pulse0 regs unchanged", r, p, m_bresp(8'h40));
    end
    axi_read(8'h40, 0, d, r, lat, ok);
    n_vec++; if (d !== 32'h0 || r !== m_rresp(8'h40)) begin n_err++; $display("FAIL unmapped_read got %h/%b expected 0/%b", d, r, m_rresp(8'h40)); end
  endtask
  task automatic test_read_during_commit();
    logic [1:0] r; logic [7:0] p; int pc, lat;
    axi_write(8'h0C, 32'h1, 4'hF, 0, r, p, pc, lat);
    m_write(8'h0C, 32'h1, 4'hF);
    axi.awaddr = 8'h0C; axi.wdata = 32'h2; axi.wstrb = 4'hF; axi.awvalid = 1; axi.wvalid = 1; axi.bready = 1;
    @(posedge clk); #1;
    axi.awvalid = 0; axi.wvalid = 0; axi.araddr = 8'h0C; axi.arvalid = 1;
    @(posedge clk); #1;
    axi.arvalid = 0;
    n_vec++; if (!axi.rvalid || axi.rdata !== 32'h1) begin n_err++; $display("FAIL commit_read got v%b %h expected v1 00000001", axi.rvalid, axi.rdata); end
    n_vec++; if (!axi.bvalid || wr_pulse !== 8'b1000) begin n_err++; $display("FAIL commit_bvalid got v%b pulse%b expected v1 pulse00001000", axi.bvalid, wr_pulse); end
    axi.rready = 1;
    @(posedge clk); #1;
    axi.rready = 0; axi.bready = 0;
    m_write(8'h0C, 32'h2, 4'hF);
    n_vec++; if (rw_regs[3] !== 32'h2) begin n_err++; $display("FAIL commit_reg3 got %h expected 00000002", rw_regs[3]); end
  endtask
  task automatic test_reset_mid_write();
    logic [1:0] r; logic [7:0] p; int pc, lat;
    axi.awaddr = 8'h10; axi.awvalid = 1;
    @(posedge clk); #1;
    axi.awvalid = 0;
    n_vec++; if ({axi.awready, axi.wready} !== 2'b01) begin n_err++; $display("FAIL have_addr_ready got %b expected 01", {axi.awready, axi.wready}); end
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    n_vec++; if (axi.bvalid !== 1'b0 || rw_regs !== '0) begin n_err++; $display("FAIL mid_reset got bvalid%b regs%h expected 0", axi.bvalid, rw_regs); end
    axi_write(8'h10, 32'h600DCAFE, 4'hF, 0, r, p, pc, lat);
    m_write(8'h10, 32'h600DCAFE, 4'hF);
    n_vec++; if (r !== 2'b00 || lat !== 1 || p !== 8'h10 || rw_regs !== m_packed()) begin
      n_err++; $display("FAIL post_reset_write got resp%b lat%0d pulse%b reg4 %h expected 00 1 00010000 600dcafe", r, lat, p, rw_regs[4]);
    end
  endtask
  task automatic test_random();
    logic [7:0] a; logic [31:0] d; logic [3:0] s; logic [1:0] r; logic [7:0] p; int pc, lat; bit ok;
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < 4; i++) ro_regs[i] = $urandom;
      a = 8'($urandom_range(0, 8'h4F));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, int'($urandom_range(0, 6)) - 3, r, p, pc, lat);
        m_write(a, d, s);
        n_vec++; if (r !== m_bresp(a) || lat !== 1) begin n_err++; $display("FAIL rand_write @%h got resp%b lat%0d expected resp%b lat1", a, r, lat, m_bresp(a)); end
        n_vec++; if (p !== m_pulse(a) || pc !== (m_pulse(a) != 0 ? 1 : 0)) begin n_err++; $display("FAIL rand_pulse @%h got %b x%0d expected %b", a, p, pc, m_pulse(a)); end
        n_vec++; if (rw_regs !== m_packed()) begin n_err++; $display("FAIL rand_regs @%h got %h expected %h", a, rw_regs, m_packed()); end
      end else begin
        axi_read(a, int'($urandom_range(0, 2)), d, r, lat, ok);
        n_vec++; if (d !== m_read(a) || r !== m_rresp(a)) begin n_err++; $display("FAIL rand_read @%h got %h/%b expected %h/%b", a, d, r, m_read(a), m_rresp(a)); end
        n_vec++; if (lat !== 0 || !ok) begin n_err++; $display("FAIL rand_read_hs @%h got lat%0d hold%0d expected lat0 hold1", a, lat, ok); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_same_cycle_write();
    test_split_order();
    test_ro_read_hold();
    test_errors();
    test_read_during_commit();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d vectors", n_vec);
    $fatal(1);
  end
endmodule
